// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers.
// Launches one frame per grant and follows tx_ready through busy and back to idle.
module uart_tx_arbiter #(
   parameter int unsigned WORD_SIZE    = 8,
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned BUSY_TIMEOUT = 8
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*WORD_SIZE-1:0] req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic                         tx_ready,
   output logic                         send_valid,
   output logic [WORD_SIZE-1:0]         data_bits,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         busy,
   output logic                         frame_done,
   output logic                         launch_err
);

   localparam int unsigned ID_W  = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [ID_W-1:0]      last_q;
   logic [ID_W-1:0]      last_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_d;
   logic [NUM_REQ-1:0]   req_ready_d;
   logic                 send_valid_d;
   logic [WORD_SIZE-1:0] data_d;
   logic [ID_W-1:0]      grant_d;
   logic                 frame_done_d;
   logic                 launch_err_d;

   logic                 pick_found;
   logic [ID_W-1:0]      pick_idx;

   // Rotating-priority pick: scan last+1, last+2, ... wrapping at NUM_REQ.
   always_comb begin : rr_pick
      int unsigned cand;
      cand       = 0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         cand = 32'(last_q) + off;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!pick_found && req_valid[ID_W'(cand)]) begin
            pick_found = 1'b1;
            pick_idx   = ID_W'(cand);
         end
      end
   end

   // Next-state and next-output decode.
   always_comb begin : fsm_next
      state_d      = state_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      req_ready_d  = '0;
      send_valid_d = 1'b0;
      data_d       = data_bits;
      grant_d      = grant_id;
      frame_done_d = 1'b0;
      launch_err_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (tx_ready && pick_found) begin
               state_d               = LAUNCH;
               last_d                = pick_idx;
               grant_d               = pick_idx;
               data_d                = req_data[32'(pick_idx) * WORD_SIZE +: WORD_SIZE];
               req_ready_d[pick_idx] = 1'b1;
               send_valid_d          = 1'b1;
            end
         end
         LAUNCH: begin
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // A transmitter that never drops tx_ready loses the word; last still advances.
            if (!tx_ready) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == CNT_LAST) begin
               launch_err_d = 1'b1;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (tx_ready) begin
               frame_done_d = 1'b1;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         last_q     <= LAST_RST;
         cnt_q      <= '0;
         req_ready  <= '0;
         send_valid <= 1'b0;
         data_bits  <= '0;
         grant_id   <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         launch_err <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         req_ready  <= req_ready_d;
         send_valid <= send_valid_d;
         data_bits  <= data_d;
         grant_id   <= grant_d;
         busy       <= (state_d != IDLE);
         frame_done <= frame_done_d;
         launch_err <= launch_err_d;
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `transmitter` UART TX instance among `NUM_REQ` byte-producing requesters. It picks one pending requester, launches a single frame with a one-cycle `send_valid` pulse, and holds `data_bits` stable for the whole frame. It then tracks the transmitter's `tx_ready` through busy and back to idle before granting again. It sits directly in front of `transmitter` and drives its `send_valid` and `data_bits` inputs.

## Interface
- `WORD_SIZE`, 8: bits per word; must match the transmitter.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `BUSY_TIMEOUT`, 8: maximum cycles after launch for `tx_ready` to fall before the launch is declared failed.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request; held high until the matching `req_ready` pulse.
- `req_data`  in  NUM_REQ*WORD_SIZE  flattened words; requester i owns bits [i*WORD_SIZE +: WORD_SIZE]; held stable while `req_valid[i]` is high.
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept pulse.
- `tx_ready`  in  1  transmitter idle indication.
- `send_valid`  out  1  one-cycle launch pulse to the transmitter.
- `data_bits`  out  WORD_SIZE  word to the transmitter; registered.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or most recent owner.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse when a launched frame completes.
- `launch_err`  out  1  one-cycle pulse on a busy timeout.

## Operation
- All outputs are registered. Reset values: `req_ready`=0, `send_valid`=0, `data_bits`=0, `grant_id`=0, `busy`=0, `frame_done`=0, `launch_err`=0, state=IDLE, round-robin pointer `last`=NUM_REQ-1, timeout counter=0.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - Acts only when `tx_ready`=1 and any `req_valid` is set.
  - Selects g = first set `req_valid` index scanning `last`+1, `last`+2, … modulo NUM_REQ.
  - Registers `data_bits`<=`req_data[g]`, `grant_id`<=g, `last`<=g, `req_ready[g]`<=1, `send_valid`<=1; goes to LAUNCH.
- **LAUNCH** (exactly 1 cycle)
  - `send_valid` and `req_ready` are high in this cycle only and drop on exit.
  - Timeout counter is cleared; goes to WAIT_BUSY.
- **WAIT_BUSY**
  - `tx_ready`=0 goes to WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches BUSY_TIMEOUT-1 with `tx_ready` still 1: pulse `launch_err`, go to IDLE.
  - The dropped word is not retried. `last` stays at g, so fairness still advances.
- **WAIT_DONE**
  - `tx_ready`=1 pulses `frame_done` and goes to IDLE.
- `data_bits` and `grant_id` change only on an IDLE accept; they are stable from LAUNCH through the return to IDLE.
- `req_valid` is ignored outside IDLE. A requester that drops `req_valid` before being granted is simply skipped; no request is latched.
- Simultaneous requests: exactly one grant per frame, in rotating order. A single persistent requester is granted back-to-back.
- `tx_ready`=0 while in IDLE: no grant is issued; the block waits.
- `rstn` low mid-frame: all state and outputs return to their reset values immediately; in-flight grants are forgotten.

## Timing
- Request in cycle T (IDLE, `tx_ready`=1) gives `send_valid`=`req_ready[g]`=1 in cycle T+1.
- Throughput bound: each frame occupies accept + LAUNCH + busy period + 1 IDLE cycle.
- `frame_done` is asserted in the cycle after `tx_ready` is sampled high in WAIT_DONE. The next accept is possible in that same cycle.
- `launch_err` is asserted BUSY_TIMEOUT+1 cycles after `send_valid`.

## Test plan
- **Single requester:** reset, `req_valid[2]`=1 with data 8'hA3 → one `send_valid` pulse, `data_bits`=8'hA3, `grant_id`=2, `req_ready`=4'b0100 in the same cycle; `frame_done` follows the `tx_ready` rise; serial line carries 0,11000101,1.
- **All four requesting continuously** with 8'h55, 8'h7E, 8'h00, 8'hFF → grant order 0,1,2,3,0 and exactly one frame in flight at any time.
- **Fairness with a late requester:** requesters 1 and 3 continuously valid, requester 0 raised mid-frame → order 1,3,0,1,3.
- **Timeout:** transmitter model holds `tx_ready`=1 after launch → `launch_err` pulses BUSY_TIMEOUT+1 cycles after `send_valid`; no `frame_done`; the next grant goes to the next requester.
- **Reset mid-frame:** assert `rstn`=0 during WAIT_DONE → all outputs 0 asynchronously; after release, pending `req_valid[0]` is granted first.
- **Held data:** change `req_data` of the granted requester after the `req_ready` pulse → `data_bits` unchanged until the next accept.
